// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM target model.
package slc3_mem_pkg;

    localparam int   WORD_W    = 16;
    localparam logic OE_ACTIVE = 1'b0;
    localparam logic WE_ACTIVE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_HOLD = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } sram_state_t;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slc3_sram_responder_array.sv
// Single-port word array: synchronous write, registered synchronous read.
module sram_array
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/slc3_sram_responder.sv
// SLC-3 SRAM bus target: wait-state FSM for CPU reads/writes plus an idle-time loader port.
module slc3_sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [15:0]       Data_to_SRAM,
    output logic [15:0]       Data_from_SRAM,
    output logic              Rd_valid,
    input  logic              Load_valid,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [15:0]       Load_data,
    output logic              Load_ready,
    output logic              Busy
);

    localparam int CNT_W = $clog2(lat_max(READ_LAT, WRITE_LAT) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RD_LAT  = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WR_LAT  = CNT_W'(WRITE_LAT);

    sram_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       addr_q;

    logic              oe_act;
    logic              we_act;
    logic              addr_same;
    logic              cpu_commit;
    logic              rd_capture;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [WORD_W-1:0] arr_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign oe_act    = (OE == OE_ACTIVE);
    assign we_act    = (WE == WE_ACTIVE);
    assign addr_same = (ADDR == addr_q);
    assign Busy      = (state != IDLE);

    // Reset gates every array write so an in-flight write can never land.
    assign Load_ready = !Reset && (state == IDLE) && !oe_act && !we_act && Load_valid;
    assign cpu_commit = !Reset && (state == WR_WAIT) && we_act && (cnt == WR_LAT);
    assign rd_capture = (state == RD_WAIT) && !we_act && oe_act && addr_same && (cnt == RD_LAT);

    assign arr_we    = cpu_commit || Load_ready;
    assign arr_addr  = Load_ready ? Load_addr : ADDR[ADDR_W-1:0];
    assign arr_wdata = Load_ready ? Load_data : Data_to_SRAM;

    sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (Clk),
        .rst   (Reset),
        .we    (arr_we),
        .re    (rd_capture),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (Data_from_SRAM)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            Rd_valid <= 1'b0;
            addr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (we_act) begin
                        state <= WR_WAIT;
                        cnt   <= CNT_ONE;
                    end else if (oe_act) begin
                        state  <= RD_WAIT;
                        cnt    <= CNT_ONE;
                        addr_q <= ADDR;
                    end
                end
                RD_WAIT: begin
                    if (we_act) begin
                        state <= WR_WAIT;
                        cnt   <= CNT_ONE;
                    end else if (!oe_act) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!addr_same) begin
                        addr_q <= ADDR;
                        cnt    <= CNT_ONE;
                    end else if (cnt == RD_LAT) begin
                        state    <= RD_HOLD;
                        Rd_valid <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                RD_HOLD: begin
                    if (we_act) begin
                        state    <= WR_WAIT;
                        cnt      <= CNT_ONE;
                        Rd_valid <= 1'b0;
                    end else if (!oe_act) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        Rd_valid <= 1'b0;
                    end else if (!addr_same) begin
                        state    <= RD_WAIT;
                        cnt      <= CNT_ONE;
                        addr_q   <= ADDR;
                        Rd_valid <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (!we_act) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == WR_LAT) begin
                        state <= WR_DONE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                WR_DONE: begin
                    // One commit per WE pulse: wait for WE to rise before re-arming.
                    if (!we_act) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    Rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
